// File: rtl/xidoo_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : xidoo_control_unit
//  Purpose  : Fetch/decode/execute sequencer for the xidoo accumulator CPU.
//             Drives every datapath strobe from IR/Aeq0/Apos status and
//             inserts MEM_WAIT wait states after each memory read setup.
//  Options  : XIDOO_CU_STEP_EN adds a single-step gate (port step) after
//             every executed instruction.
//  Revision : 1.0  initial release
// ============================================================================
module xidoo_control_unit #(
   parameter int MEM_WAIT = 0,
   parameter int WAIT_W   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] IR,
   input  logic       Aeq0,
   input  logic       Apos,
   input  logic       enter,
`ifdef XIDOO_CU_STEP_EN
   input  logic       step,
`endif
   output logic       IRload,
   output logic       JMPmux,
   output logic       PCload,
   output logic       Meminst,
   output logic       MemWr,
   output logic [1:0] Asel,
   output logic       Aload,
   output logic       Sub,
   output logic       halted,
   output logic       wait_in
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_FWAIT  = 4'd1,
      S_LOADIR = 4'd2,
      S_DECODE = 4'd3,
      S_OWAIT  = 4'd4,
      S_LOAD   = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_IN     = 4'd9,
      S_JZ     = 4'd10,
      S_JPOS   = 4'd11,
      S_HALT   = 4'd12,
      S_STEP   = 4'd13
   } state_t;

   // Terminal count of the wait counter; unused when there are no wait states.
   localparam logic              c_has_wait  = (MEM_WAIT > 0);
   localparam logic [WAIT_W-1:0] c_last_wait = (MEM_WAIT > 0) ? WAIT_W'(MEM_WAIT - 1) : '0;

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_cnt;
   logic [WAIT_W-1:0] w_cnt_next;
   logic [2:0]        r_op;
   logic              w_wait_done;
   logic              w_mem_op;
   state_t            w_after_exec;

   // Map an opcode onto the state that executes it.
   function automatic state_t exec_of(input logic [2:0] op);
      case (op)
         3'b000:  return S_LOAD;
         3'b001:  return S_STORE;
         3'b010:  return S_ADD;
         3'b011:  return S_SUB;
         3'b100:  return S_IN;
         3'b101:  return S_JZ;
         3'b110:  return S_JPOS;
         default: return S_HALT;
      endcase
   endfunction

   assign w_wait_done = (r_cnt == c_last_wait);
   // Only instructions that read an operand from memory need operand wait states.
   assign w_mem_op    = (IR == 3'b000) || (IR == 3'b010) || (IR == 3'b011);

`ifdef XIDOO_CU_STEP_EN
   assign w_after_exec = S_STEP;
`else
   assign w_after_exec = S_FETCH;
`endif

   // State, wait counter and pending opcode registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
         r_op    <= 3'b000;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (r_state == S_DECODE) begin
            r_op <= IR;
         end
      end
   end

   // Next-state logic and Moore strobe decode (IN/JZ/JPOS qualify on live inputs).
   always_comb begin
      w_next     = r_state;
      w_cnt_next = '0;
      IRload     = 1'b0;
      JMPmux     = 1'b0;
      PCload     = 1'b0;
      Meminst    = 1'b0;
      MemWr      = 1'b0;
      Asel       = 2'b00;
      Aload      = 1'b0;
      Sub        = 1'b0;
      halted     = 1'b0;
      wait_in    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_next = c_has_wait ? S_FWAIT : S_LOADIR;
         end
         S_FWAIT: begin
            if (w_wait_done) begin
               w_next = S_LOADIR;
            end else begin
               w_cnt_next = r_cnt + WAIT_W'(1);
            end
         end
         S_LOADIR: begin
            IRload = 1'b1;
            PCload = 1'b1;
            w_next = S_DECODE;
         end
         S_DECODE: begin
            Meminst = 1'b1;
            if (IR == 3'b111) begin
               w_next = S_HALT;
            end else if (w_mem_op && c_has_wait) begin
               w_next = S_OWAIT;
            end else begin
               w_next = exec_of(IR);
            end
         end
         S_OWAIT: begin
            Meminst = 1'b1;
            if (w_wait_done) begin
               w_next = exec_of(r_op);
            end else begin
               w_cnt_next = r_cnt + WAIT_W'(1);
            end
         end
         S_LOAD: begin
            Meminst = 1'b1;
            Asel    = 2'b10;
            Aload   = 1'b1;
            w_next  = w_after_exec;
         end
         S_STORE: begin
            Meminst = 1'b1;
            MemWr   = 1'b1;
            w_next  = w_after_exec;
         end
         S_ADD: begin
            Meminst = 1'b1;
            Aload   = 1'b1;
            w_next  = w_after_exec;
         end
         S_SUB: begin
            Meminst = 1'b1;
            Aload   = 1'b1;
            Sub     = 1'b1;
            w_next  = w_after_exec;
         end
         S_IN: begin
            wait_in = 1'b1;
            if (enter) begin
               Asel   = 2'b01;
               Aload  = 1'b1;
               w_next = w_after_exec;
            end
         end
         S_JZ: begin
            JMPmux = 1'b1;
            PCload = Aeq0;
            w_next = w_after_exec;
         end
         S_JPOS: begin
            JMPmux = 1'b1;
            PCload = Apos & ~Aeq0;
            w_next = w_after_exec;
         end
         S_HALT: begin
            halted = 1'b1;
         end
`ifdef XIDOO_CU_STEP_EN
         S_STEP: begin
            if (step) begin
               w_next = S_FETCH;
            end
         end
`endif
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

endmodule
`default_nettype wire
